// File: rtl/burst_sched_pkg.sv
// Shared definitions for the burst scheduler.
// Holds the FSM state enum, error code values, the counter width,
// the fixed arm timeout and the default parameter values.
package burst_sched_pkg;

  localparam int unsigned DefNumReq       = 4;
  localparam int unsigned DefWakeLen      = 4;
  localparam int unsigned DefSyncTimeout  = 20000;
  localparam int unsigned DefBurstTimeout = 150000;
  localparam int unsigned DefGuardLen     = 100;

  // Shared timeout counter width and the fixed wait-for-arm window.
  localparam int unsigned CntWidth   = 20;
  localparam int unsigned ArmTimeout = 16;

  typedef enum logic [2:0] {
    StIdle,
    StWake,
    StWaitArm,
    StWaitSync,
    StBurst,
    StGuard
  } state_e;

  localparam logic [1:0] ErrNone  = 2'd0;
  localparam logic [1:0] ErrNoArm = 2'd1;
  localparam logic [1:0] ErrSync  = 2'd2;
  localparam logic [1:0] ErrBurst = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter, purely combinational.
// Ports:
//   i_req   - request vector
//   i_last  - index of the previous winner; search begins at i_last+1 and wraps
//   o_grant - one-hot winner (all-zero when no request)
//   o_idx   - index of the winner
//   o_valid - at least one request present
module rr_arbiter
  import burst_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  int unsigned w_idx;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_idx   = 0;
    // k runs 1..NUM_REQ so the previous winner is visited last.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = (32'(i_last) + k) % NUM_REQ;
      if (!o_valid && i_req[w_idx]) begin
        o_valid        = 1'b1;
        o_idx          = IDX_W'(w_idx);
        o_grant[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/burst_scheduler.sv
// Burst scheduler: grants one requester at a time the shared
// wake-up / sync / data-clock datapath and supervises each phase.
// Ports:
//   clki         - system clock (rising edge)
//   rst          - synchronous active-high reset
//   req          - per-requester level request
//   wu_valid     - datapath armed after wake-up
//   data_clk_enb - datapath burst-active indication
//   grant        - one-hot owner of the current burst, zero when idle
//   wake_up      - wake-up pulse, WAKE_LEN cycles
//   busy         - high outside IDLE
//   err_pulse    - one-cycle pulse on any timeout
//   err_code     - last error cause, held until the next error or reset
module burst_scheduler
  import burst_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ       = DefNumReq,
  parameter int unsigned WAKE_LEN      = DefWakeLen,
  parameter int unsigned SYNC_TIMEOUT  = DefSyncTimeout,
  parameter int unsigned BURST_TIMEOUT = DefBurstTimeout,
  parameter int unsigned GUARD_LEN     = DefGuardLen
) (
  input  logic               clki,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               wu_valid,
  input  logic               data_clk_enb,
  output logic [NUM_REQ-1:0] grant,
  output logic               wake_up,
  output logic               busy,
  output logic               err_pulse,
  output logic [1:0]         err_code
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Each threshold is the counter value of the last cycle spent in a state,
  // so a state lasts exactly that many cycles.
  localparam logic [CntWidth-1:0] CntMax   = '1;
  localparam logic [CntWidth-1:0] WakeEnd  = CntWidth'(WAKE_LEN);
  localparam logic [CntWidth-1:0] ArmEnd   = CntWidth'(ArmTimeout - 1);
  localparam logic [CntWidth-1:0] SyncEnd  = CntWidth'(SYNC_TIMEOUT - 1);
  localparam logic [CntWidth-1:0] BurstEnd = CntWidth'(BURST_TIMEOUT - 1);
  localparam logic [CntWidth-1:0] GuardEnd = CntWidth'(GUARD_LEN - 1);

  state_e              r_state;
  logic [CntWidth-1:0] r_cnt;
  logic [NUM_REQ-1:0]  r_grant;
  logic [IdxW-1:0]     r_last;
  logic                r_err_pulse;
  logic [1:0]          r_err_code;
  logic                r_dce;

  state_e              w_state_d;
  logic [NUM_REQ-1:0]  w_grant_d;
  logic [IdxW-1:0]     w_last_d;
  logic                w_err_pulse_d;
  logic [1:0]          w_err_code_d;

  logic [NUM_REQ-1:0]  w_arb_grant;
  logic [IdxW-1:0]     w_arb_idx;
  logic                w_arb_valid;
  logic                w_rise;
  logic                w_fall;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_rr_arbiter (
    .i_req   (req),
    .i_last  (r_last),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  assign w_rise = data_clk_enb & ~r_dce;
  assign w_fall = ~data_clk_enb & r_dce;

  always_comb begin
    w_state_d     = r_state;
    w_grant_d     = r_grant;
    w_last_d      = r_last;
    w_err_pulse_d = 1'b0;
    w_err_code_d  = r_err_code;
    unique case (r_state)
      StIdle: begin
        if (w_arb_valid) begin
          w_state_d = StWake;
          w_grant_d = w_arb_grant;
          w_last_d  = w_arb_idx;
        end
      end
      StWake: begin
        if (r_cnt >= WakeEnd) w_state_d = StWaitArm;
      end
      StWaitArm: begin
        if (wu_valid) begin
          w_state_d = StWaitSync;
        end else if (r_cnt >= ArmEnd) begin
          w_state_d     = StGuard;
          w_grant_d     = '0;
          w_err_pulse_d = 1'b1;
          w_err_code_d  = ErrNoArm;
        end
      end
      StWaitSync: begin
        // Edge is tested first so a coincident timeout is not reported.
        if (w_rise) begin
          w_state_d = StBurst;
        end else if (r_cnt >= SyncEnd) begin
          w_state_d     = StGuard;
          w_grant_d     = '0;
          w_err_pulse_d = 1'b1;
          w_err_code_d  = ErrSync;
        end
      end
      StBurst: begin
        if (w_fall) begin
          w_state_d = StGuard;
          w_grant_d = '0;
        end else if (r_cnt >= BurstEnd) begin
          w_state_d     = StGuard;
          w_grant_d     = '0;
          w_err_pulse_d = 1'b1;
          w_err_code_d  = ErrBurst;
        end
      end
      StGuard: begin
        if (r_cnt >= GuardEnd) w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
        w_grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clki) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_grant     <= '0;
      r_last      <= IdxW'(NUM_REQ - 1);
      r_err_pulse <= 1'b0;
      r_err_code  <= ErrNone;
      r_dce       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_grant     <= w_grant_d;
      r_last      <= w_last_d;
      r_err_pulse <= w_err_pulse_d;
      r_err_code  <= w_err_code_d;
      r_dce       <= data_clk_enb;
      if (w_state_d != r_state) begin
        r_cnt <= '0;
      end else if (r_cnt != CntMax) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign grant     = r_grant;
  // The first WAKE cycle is the grant cycle, so wake_up follows grant by one cycle.
  assign wake_up   = (r_state == StWake) && (r_cnt != '0);
  assign busy      = (r_state != StIdle);
  assign err_pulse = r_err_pulse;
  assign err_code  = r_err_code;

endmodule

// File: doc/burst_scheduler.md
BURST_SCHEDULER -- requirements
Module: burst_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the wake-up/sync/data-clock datapath.
REQ-002 Parameter WAKE_LEN, default 4: wake_up pulse width, in clki cycles.
REQ-003 Parameter SYNC_TIMEOUT, default 20000: maximum cycles from wake_up falling to data_clk_enb rising (200 us at 100 MHz).
REQ-004 Parameter BURST_TIMEOUT, default 150000: maximum cycles data_clk_enb may stay high (1216 bits at 1 MHz, plus margin).
REQ-005 Parameter GUARD_LEN, default 100: idle cycles enforced between bursts.
REQ-006 clki  input  1  single system clock; all logic on its rising edge.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 req  input  NUM_REQ  per-requester burst request, level; held until grant is seen.
REQ-009 wu_valid  input  1  datapath has accepted the wake-up and is armed for sync.
REQ-010 data_clk_enb  input  1  datapath burst-active indication.
REQ-011 grant  output  NUM_REQ  one-hot owner of the current burst; all-zero when idle.
REQ-012 wake_up  output  1  wake-up pulse to the datapath.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 err_pulse  output  1  one-cycle pulse on any timeout.
REQ-015 err_code  output  2  0=none, 1=no wu_valid, 2=sync timeout, 3=burst timeout; held until the next err_pulse or reset.

Function
REQ-016 The FSM SHALL have the states IDLE, WAKE, WAIT_ARM, WAIT_SYNC, BURST and GUARD.
REQ-017 IDLE: if any req bit is high, the block SHALL select one winner round-robin, register grant one-hot, and enter WAKE on the next cycle.
REQ-018 Round-robin: search SHALL start at the index after the last winner, wrap at NUM_REQ-1 to 0, and start at index 0 after reset.
REQ-019 WAKE: wake_up SHALL be high for exactly WAKE_LEN cycles, then the FSM SHALL enter WAIT_ARM.
REQ-020 WAIT_ARM: on wu_valid high, go to WAIT_SYNC; if wu_valid is not seen within 16 cycles, set err_code=1, pulse err_pulse, go to GUARD.
REQ-021 WAIT_SYNC: on a data_clk_enb rising edge (registered previous value 0, current 1), go to BURST; if the counter reaches SYNC_TIMEOUT, set err_code=2, pulse err, go to GUARD.
REQ-022 BURST: on a data_clk_enb falling edge, go to GUARD; if the counter reaches BURST_TIMEOUT, set err_code=3, pulse err, go to GUARD.
REQ-023 GUARD: grant SHALL be cleared on entry; hold GUARD_LEN cycles, then go to IDLE; new requests SHALL NOT be sampled during GUARD.
REQ-024 One 20-bit timeout counter SHALL be shared across states, cleared on every state transition; it SHALL saturate and never wrap.
REQ-025 Deasserting req for the granted requester mid-burst SHALL NOT abort the burst; grant is held until GUARD.
REQ-026 If the timeout threshold and the expected edge occur in the same cycle, the edge SHALL take priority (no error).
REQ-027 At most one grant bit SHALL be high at any time; wake_up SHALL be high only in WAKE.
REQ-028 Latency: req high in IDLE -> grant in the next cycle -> wake_up in the cycle after that.

Reset
REQ-029 While rst is high on a clock edge: state=IDLE, grant=0, wake_up=0, busy=0, err_pulse=0, err_code=0, counter=0, RR pointer=NUM_REQ-1; mid-burst reset SHALL take effect on the next edge without waiting for data_clk_enb to fall.

Structure
REQ-030 Package burst_sched_pkg SHALL hold the state enum, err_code constants and default parameter values.
REQ-031 Sub-module rr_arbiter (req, last-winner pointer -> one-hot winner, valid) SHALL be the only instance.

Verification
REQ-032 Single request: req=4'b0010 -> grant=0010 at cycle+1, wake_up high for 4 cycles, wu_valid then data_clk_enb high 1216 us -> GUARD 100 cycles -> IDLE, err_code=0.
REQ-033 Fairness: req=4'b1111 held for 4 bursts -> grant order 0001, 0010, 0100, 1000; 5th burst -> 0001.
REQ-034 Sync timeout: wu_valid given, data_clk_enb never rises -> err_pulse exactly 20000 cycles after WAIT_SYNC entry, err_code=2, grant cleared.
REQ-035 Missing arm: wu_valid never asserted -> err_code=1 after 16 cycles, next requester served after GUARD.
REQ-036 Reset mid-BURST: rst pulsed for 1 cycle -> all outputs 0 next cycle; the next req=4'b0100 is granted (pointer reset).
REQ-037 Edge/timeout collision: data_clk_enb rises on cycle SYNC_TIMEOUT -> BURST entered, no err_pulse.
